// File: rtl/store_commit_scheduler_pkg.sv
// Shared parameters, entry record and FSM encoding for the store commit path.
// Widths here are the codebase-wide store/ROB parameters.
package store_commit_scheduler_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int RB_INDEX   = 4;
    localparam int FU_NUM     = 4;
    localparam int STORER_NUM = 2;

    localparam logic [RB_INDEX-1:0] NULL = '0;

    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        logic [RB_INDEX-1:0]  rbi;
    } sb_entry_t;

    localparam int ENTRY_W = $bits(sb_entry_t);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/store_commit_scheduler_fifo.sv
// In-order committed-store FIFO with head/second-entry views.
// STORE_FWD_EN adds a youngest-match address lookup over the live entries.
module store_fifo
    import store_commit_scheduler_pkg::*;
#(
    parameter int SB_DEPTH = 4,
    localparam int PW = $clog2(SB_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  sb_entry_t      push_entry,
    input  logic           pop,
    output sb_entry_t      head,
    output sb_entry_t      second,
`ifdef STORE_FWD_EN
    input  logic [WORD_SIZE-1:0] ld_addr,
    output logic                 ld_hit,
    output logic [WORD_SIZE-1:0] ld_data,
`endif
    output logic [CW-1:0]  count
);

    sb_entry_t        mem [SB_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + PW'(1)];

`ifdef STORE_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = rd_ptr;
        for (int i = 0; i < SB_DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (CW'(i) < count && mem[fwd_idx].addr == ld_addr) begin
                ld_hit  = 1'b1;
                ld_data = mem[fwd_idx].data;
            end
        end
    end
`endif

endmodule

// File: rtl/store_commit_scheduler.sv
// Holds completed stores until ROB commit, then writes them to memory in order.
// Optional store-to-load forwarding lookup is enabled with STORE_FWD_EN.
module store_commit_scheduler
    import store_commit_scheduler_pkg::*;
#(
    parameter int SB_DEPTH       = 4,
    parameter int STORER_FU_BASE = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [FU_NUM-1:0]               valid_bus,
    input  logic [FU_NUM*WORD_SIZE-1:0]     data_bus,
    input  logic [STORER_NUM*WORD_SIZE-1:0] addr_bus,
    input  logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus,
    input  logic                            commit_valid,
    input  logic [RB_INDEX-1:0]             commit_index,
    output logic                            commit_stall,
    input  logic                            flush,
    output logic                            mem_we,
    output logic [WORD_SIZE-1:0]            mem_addr,
    output logic [WORD_SIZE-1:0]            mem_wdata,
    input  logic                            mem_ack,
    output logic                            done_valid,
    output logic [RB_INDEX-1:0]             done_index,
`ifdef STORE_FWD_EN
    input  logic [WORD_SIZE-1:0]            ld_addr,
    output logic                            ld_hit,
    output logic [WORD_SIZE-1:0]            ld_data,
`endif
    output logic                            sb_empty
);

    localparam int CW = $clog2(SB_DEPTH) + 1;

    sb_entry_t               slot   [STORER_NUM];
    sb_entry_t               bus_e  [STORER_NUM];
    logic [STORER_NUM-1:0]   occ;
    logic [STORER_NUM-1:0]   cap;
    logic [STORER_NUM-1:0]   sel_oh;
    logic                    hit;
    logic                    byp;
    sb_entry_t               commit_entry;
    logic                    match;
    logic                    full;
    logic                    push;
    logic                    pop;
    sb_entry_t               head;
    sb_entry_t               second;
    logic [CW-1:0]           count;
    wr_state_t               state;
    logic [RB_INDEX-1:0]     cur_rbi;

    // Non-storer lanes of the shared result buses are not consumed here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{valid_bus, data_bus, RB_index_bus};

    // Decode storer lanes, capture qualification and the commit match.
    always_comb begin
        hit          = 1'b0;
        byp          = 1'b0;
        sel_oh       = '0;
        cap          = '0;
        commit_entry = '0;
        for (int s = 0; s < STORER_NUM; s++) begin
            bus_e[s].addr = addr_bus[s*WORD_SIZE +: WORD_SIZE];
            bus_e[s].data = data_bus[(STORER_FU_BASE+s)*WORD_SIZE +: WORD_SIZE];
            bus_e[s].rbi  = RB_index_bus[(STORER_FU_BASE+s)*RB_INDEX +: RB_INDEX];
            cap[s] = valid_bus[STORER_FU_BASE+s]
                   && !(occ[s] && slot[s].rbi == bus_e[s].rbi);
            if (!hit && occ[s] && slot[s].rbi == commit_index) begin
                hit          = 1'b1;
                sel_oh[s]    = 1'b1;
                commit_entry = slot[s];
            end else if (!hit && cap[s] && bus_e[s].rbi == commit_index) begin
                hit          = 1'b1;
                byp          = 1'b1;
                sel_oh[s]    = 1'b1;
                commit_entry = bus_e[s];
            end
        end
    end

    assign match        = commit_valid && hit;
    assign full         = (count == CW'(SB_DEPTH));
    assign commit_stall = match && full;
    assign push         = match && !full;
    assign pop          = (state == S_WRITE) && mem_ack;
    assign sb_empty     = (count == '0) && (state == S_IDLE);

    // Capture slots: load new stores, free committed ones, flush clears all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ <= '0;
            for (int s = 0; s < STORER_NUM; s++) slot[s] <= '0;
        end else begin
            for (int s = 0; s < STORER_NUM; s++) begin
                if (cap[s] && !(push && sel_oh[s] && byp)) begin
                    slot[s] <= bus_e[s];
                end
                if (flush) begin
                    occ[s] <= 1'b0;
                end else if (cap[s] && !(push && sel_oh[s] && byp)) begin
                    occ[s] <= 1'b1;
                end else if (push && sel_oh[s] && !byp) begin
                    occ[s] <= 1'b0;
                end
            end
        end
    end

    store_fifo #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (commit_entry),
        .pop        (pop),
        .head       (head),
        .second     (second),
`ifdef STORE_FWD_EN
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
`endif
        .count      (count)
    );

    // Write FSM: present the head, hold until ack, then chain or go idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cur_rbi    <= NULL;
            done_valid <= 1'b0;
            done_index <= NULL;
        end else begin
            done_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state     <= S_WRITE;
                        mem_we    <= 1'b1;
                        mem_addr  <= head.addr;
                        mem_wdata <= head.data;
                        cur_rbi   <= head.rbi;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        done_valid <= 1'b1;
                        done_index <= cur_rbi;
                        if (count > CW'(1)) begin
                            mem_addr  <= second.addr;
                            mem_wdata <= second.data;
                            cur_rbi   <= second.rbi;
                        end else begin
                            state  <= S_IDLE;
                            mem_we <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_commit_scheduler.sv
// Scoreboard bench for store_commit_scheduler (SB_DEPTH 4, two storers).
// Expected writes are queued at commit and checked as memory accepts them.
module tb_store_commit_scheduler;
    import store_commit_scheduler_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset;
    logic [FU_NUM-1:0]               valid_bus;
    logic [FU_NUM*WORD_SIZE-1:0]     data_bus;
    logic [STORER_NUM*WORD_SIZE-1:0] addr_bus;
    logic [FU_NUM*RB_INDEX-1:0]      RB_index_bus;
    logic                            commit_valid;
    logic [RB_INDEX-1:0]             commit_index;
    logic                            commit_stall;
    logic                            flush;
    logic                            mem_we;
    logic [WORD_SIZE-1:0]            mem_addr;
    logic [WORD_SIZE-1:0]            mem_wdata;
    logic                            mem_ack;
    logic                            done_valid;
    logic [RB_INDEX-1:0]             done_index;
    logic                            sb_empty;
`ifdef STORE_FWD_EN
    logic [WORD_SIZE-1:0]            ld_addr;
    logic                            ld_hit;
    logic [WORD_SIZE-1:0]            ld_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int w0;

    sb_entry_t           exp_q[$];
    logic [RB_INDEX-1:0] done_q[$];

    store_commit_scheduler #(
        .SB_DEPTH       (4),
        .STORER_FU_BASE (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_bus    (valid_bus),
        .data_bus     (data_bus),
        .addr_bus     (addr_bus),
        .RB_index_bus (RB_index_bus),
        .commit_valid (commit_valid),
        .commit_index (commit_index),
        .commit_stall (commit_stall),
        .flush        (flush),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .done_valid   (done_valid),
        .done_index   (done_index),
`ifdef STORE_FWD_EN
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_data      (ld_data),
`endif
        .sb_empty     (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int s, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] r);
        valid_bus[s]                     = 1'b1;
        addr_bus[s*WORD_SIZE +: WORD_SIZE] = a;
        data_bus[s*WORD_SIZE +: WORD_SIZE] = d;
        RB_index_bus[s*RB_INDEX +: RB_INDEX] = r;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] r);
        sb_entry_t e;
        e.addr = a;
        e.data = d;
        e.rbi  = r;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k;
        mem_ack = 1'b1;
        k = 0;
        while (!(sb_empty && exp_q.size() == 0) && k < budget) begin
            step();
            k++;
        end
        check("drain_done", {63'd0, sb_empty}, 64'd1);
        step();
    endtask

    // Monitor: accepted writes against queued commits, done pulses against accepts.
    always @(negedge clk) begin
        if (!reset) begin
            if (done_valid) begin
                if (done_q.size() == 0) begin
                    check("done_unexp", 64'd1, 64'd0);
                end else begin
                    check("done_index", 64'(done_index), 64'(done_q.pop_front()));
                end
            end
            if (mem_we) we_cnt++;
            if (mem_we && mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexp", 64'd1, 64'd0);
                end else begin
                    sb_entry_t e;
                    e = exp_q.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                    done_q.push_back(e.rbi);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        valid_bus    = '0;
        data_bus     = '0;
        addr_bus     = '0;
        RB_index_bus = '0;
        commit_valid = 1'b0;
        commit_index = '0;
        flush        = 1'b0;
        mem_ack      = 1'b0;
`ifdef STORE_FWD_EN
        ld_addr      = '0;
`endif
        repeat (2) step();
        @(negedge clk);
        check("rst_we", {63'd0, mem_we}, 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_done", {63'd0, done_valid}, 64'd0);
        check("rst_didx", 64'(done_index), 64'(NULL));
        check("rst_empty", {63'd0, sb_empty}, 64'd1);
        step();
        reset = 1'b0;
        step();

        // Single store: capture, commit, one-cycle write with ack high.
        mem_ack = 1'b1;
        w0 = we_cnt;
        lane(0, 32'h10, 32'h55, 4'd3);
        step();
        valid_bus = '0;
        commit_valid = 1'b1;
        commit_index = 4'd3;
        expect_wr(32'h10, 32'h55, 4'd3);
        step();
        commit_valid = 1'b0;
        @(negedge clk);
        check("lat_we_low", {63'd0, mem_we}, 64'd0);
        check("lat_not_empty", {63'd0, sb_empty}, 64'd0);
        step();
        @(negedge clk);
        check("lat_we_high", {63'd0, mem_we}, 64'd1);
        drain(20);
        check("one_write", 64'(we_cnt - w0), 64'd1);

        // Two storers same cycle; commit order decides write order.
        lane(0, 32'h100, 32'hA0, 4'd1);
        lane(1, 32'h104, 32'hB1, 4'd2);
        step();
        valid_bus = '0;
        commit_valid = 1'b1;
        commit_index = 4'd2;
        expect_wr(32'h104, 32'hB1, 4'd2);
        step();
        commit_index = 4'd1;
        expect_wr(32'h100, 32'hA0, 4'd1);
        step();
        commit_valid = 1'b0;
        drain(20);

        // Fill FIFO with ack low using bypass commits, then stall on a 5th.
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane(0, 32'h200 + 32'(4*i), 32'h1000 + 32'(i), 4'(8 + i));
            commit_valid = 1'b1;
            commit_index = 4'(8 + i);
            @(negedge clk);
            check("fill_nostall", {63'd0, commit_stall}, 64'd0);
            expect_wr(32'h200 + 32'(4*i), 32'h1000 + 32'(i), 4'(8 + i));
            step();
        end
        valid_bus = '0;
        commit_valid = 1'b0;
        lane(1, 32'h300, 32'h2000, 4'd12);
        step();
        valid_bus = '0;
        commit_valid = 1'b1;
        commit_index = 4'd12;
        @(negedge clk);
        check("stall_full", {63'd0, commit_stall}, 64'd1);
        step();
        @(negedge clk);
        check("stall_held", {63'd0, commit_stall}, 64'd1);
        step();
        mem_ack = 1'b1;
        @(negedge clk);
        check("stall_with_pop", {63'd0, commit_stall}, 64'd1);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        check("stall_drop", {63'd0, commit_stall}, 64'd0);
        expect_wr(32'h300, 32'h2000, 4'd12);
        step();
        commit_valid = 1'b0;
        drain(40);

        // Flush with same-cycle commit; the other captured store is squashed.
        w0 = we_cnt;
        lane(0, 32'h40, 32'h77, 4'd5);
        lane(1, 32'h44, 32'h88, 4'd6);
        step();
        valid_bus = '0;
        commit_valid = 1'b1;
        commit_index = 4'd5;
        flush = 1'b1;
        expect_wr(32'h40, 32'h77, 4'd5);
        step();
        flush = 1'b0;
        commit_index = 4'd6;
        @(negedge clk);
        check("flushed_nostall", {63'd0, commit_stall}, 64'd0);
        step();
        commit_valid = 1'b0;
        drain(20);
        check("flush_one_write", 64'(we_cnt - w0), 64'd1);

`ifdef STORE_FWD_EN
        // Forwarding returns the youngest matching FIFO entry.
        mem_ack = 1'b0;
        lane(0, 32'h20, 32'h7, 4'd1);
        commit_valid = 1'b1;
        commit_index = 4'd1;
        expect_wr(32'h20, 32'h7, 4'd1);
        step();
        lane(0, 32'h20, 32'h9, 4'd2);
        commit_index = 4'd2;
        expect_wr(32'h20, 32'h9, 4'd2);
        step();
        lane(0, 32'h24, 32'h3, 4'd4);
        commit_index = 4'd4;
        expect_wr(32'h24, 32'h3, 4'd4);
        step();
        valid_bus = '0;
        commit_valid = 1'b0;
        ld_addr = 32'h20;
        #1;
        check("fwd_hit", {63'd0, ld_hit}, 64'd1);
        check("fwd_data", 64'(ld_data), 64'd9);
        ld_addr = 32'h30;
        #1;
        check("fwd_miss", {63'd0, ld_hit}, 64'd0);
        check("fwd_miss_data", 64'(ld_data), 64'd0);
        drain(40);
`endif

        // Asynchronous reset in the middle of a write.
        mem_ack = 1'b0;
        lane(0, 32'h50, 32'h99, 4'd9);
        commit_valid = 1'b1;
        commit_index = 4'd9;
        expect_wr(32'h50, 32'h99, 4'd9);
        step();
        valid_bus = '0;
        commit_valid = 1'b0;
        step();
        @(negedge clk);
        check("pre_rst_we", {63'd0, mem_we}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_we", {63'd0, mem_we}, 64'd0);
        check("async_empty", {63'd0, sb_empty}, 64'd1);
        check("async_done", {63'd0, done_valid}, 64'd0);
        exp_q.delete();
        done_q.delete();
        mem_ack = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("post_rst_we", {63'd0, mem_we}, 64'd0);
        check("post_rst_empty", {63'd0, sb_empty}, 64'd1);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
